// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver and transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // 2-of-3 majority vote used to filter line samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one tick every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned DIV_L = (DIV == 0) ? 1 : DIV;
  localparam int unsigned CW    = (DIV_L > 1) ? $clog2(DIV_L) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_L - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count; the tick flop mirrors "counter is at its last value".
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  // Divider state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority-vote sampling and optional parity.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600,
  parameter parity_e     PARITY    = PAR_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       en_rx,
  output logic [7:0] doutrx,
  output logic       donerx,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV_RAW = clk_freq / (baud_rate * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;

  // Bit-local tick numbers: samples at 7 and 8, decision at 9, bit end at 15.
  localparam logic [3:0] T_S0  = 4'd7;
  localparam logic [3:0] T_S1  = 4'd8;
  localparam logic [3:0] T_DEC = 4'd9;
  localparam logic [3:0] T_END = 4'd15;

  logic       sync1_q, rxs_q, rxs_prev_q;
  logic       tick, start_c, maj, dec, bit_end;
  logic [3:0] tnum;

  rx_state_e  state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] samp_q, samp_d;
  logic       perr_q, perr_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic       pout_q, pout_d;
  logic       busy_q, busy_d;

  // Two-flop synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (start_c),
    .tick    (tick)
  );

  assign start_c = (state_q == ST_IDLE) && en_rx && rxs_prev_q && !rxs_q;
  assign tnum    = tcnt_q + 4'd1;
  assign maj     = maj3(samp_q[0], samp_q[1], rxs_q);
  assign dec     = tick && (tnum == T_DEC);
  assign bit_end = tick && (tnum == T_END);

  // Next-state and output decode for the receive FSM.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    samp_d  = samp_q;
    perr_d  = perr_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    pout_d  = 1'b0;

    if (tick && (state_q != ST_IDLE)) begin
      tcnt_d = tnum;
      if (tnum == T_S0) samp_d[0] = rxs_q;
      if (tnum == T_S1) samp_d[1] = rxs_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_START;
          tcnt_d  = '0;
          bcnt_d  = '0;
          shreg_d = '0;
          perr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (dec && maj) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (dec) shreg_d = {maj, shreg_q[7:1]};
        if (bit_end) begin
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (dec) perr_d = ((^shreg_q) ^ maj) != (PARITY == PAR_ODD);
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (dec) begin
          dout_d  = shreg_q;
          done_d  = 1'b1;
          ferr_d  = !maj;
          pout_d  = perr_q && (PARITY != PAR_NONE);
          state_d = maj ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping the enable abandons any frame in progress without output.
    if (!en_rx && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      pout_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      samp_q  <= '0;
      perr_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      samp_q  <= samp_d;
      perr_q  <= perr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      pout_q  <= pout_d;
      busy_q  <= busy_d;
    end
  end

  assign doutrx     = dout_q;
  assign donerx     = done_q;
  assign frame_err  = ferr_q;
  assign parity_err = pout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: one receiver without parity, one with even parity.
`timescale 1ns/1ps
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 3200000;
  localparam int unsigned BAUD     = 100000;
  localparam int          BIT      = 32;

  logic       clk;
  logic       rst, en_rx, rx_n, rx_e;
  logic [7:0] dout_n, dout_e;
  logic       done_n, done_e, fe_n, fe_e, pe_n, pe_e, busy_n, busy_e;

  uart_rx_os #(.clk_freq(CLK_FREQ), .baud_rate(BAUD), .PARITY(PAR_NONE)) u_none (
    .clk(clk), .rst(rst), .rx(rx_n), .en_rx(en_rx), .doutrx(dout_n), .donerx(done_n),
    .frame_err(fe_n), .parity_err(pe_n), .busy(busy_n)
  );

  uart_rx_os #(.clk_freq(CLK_FREQ), .baud_rate(BAUD), .PARITY(PAR_EVEN)) u_even (
    .clk(clk), .rst(rst), .rx(rx_e), .en_rx(en_rx), .doutrx(dout_e), .donerx(done_e),
    .frame_err(fe_e), .parity_err(pe_e), .busy(busy_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every donerx pulse with the flags that accompany it.
  int         cnt_n = 0, cnt_e = 0, t_done_n = 0;
  logic [7:0] cap_dout_n, cap_dout_e;
  logic       cap_fe_n, cap_fe_e, cap_pe_n, cap_pe_e;
  always @(negedge clk) begin
    if (done_n) begin
      cnt_n = cnt_n + 1;
      cap_dout_n = dout_n;
      cap_fe_n = fe_n;
      cap_pe_n = pe_n;
      t_done_n = cyc;
    end
    if (done_e) begin
      cnt_e = cnt_e + 1;
      cap_dout_e = dout_e;
      cap_fe_e = fe_e;
      cap_pe_e = pe_e;
    end
  end

  int checks = 0, errors = 0;
  int t_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic val, input int n);
    if (sel) rx_e = val;
    else     rx_n = val;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits LSB first, optional parity, stop held for stop_len clocks.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input bit pbit, input bit stopb, input int stop_len,
                            input int gbit);
    t_start = cyc;
    drive(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        drive(sel, d[i], 16);
        drive(sel, ~d[i], 1);
        drive(sel, d[i], BIT - 17);
      end else begin
        drive(sel, d[i], BIT);
      end
    end
    if (has_par) drive(sel, pbit, BIT);
    drive(sel, stopb, stop_len);
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         pbit;
    bit         stopb;
    logic [7:0] exp_dout;
    bit         exp_fe;
    bit         exp_pe;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int         c0, lat;
  logic [7:0] v8;

  initial begin
    vecs[0] = '{1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h96, 1'b0, 1'b0, 8'h96, 1'b1, 1'b0};

    rst = 1'b0; en_rx = 1'b1; rx_n = 1'b1; rx_e = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst dout_n", dout_n, 8'h00);
    check("rst done_n", done_n, 1'b0);
    check("rst fe_n",   fe_n,   1'b0);
    check("rst pe_n",   pe_n,   1'b0);
    check("rst busy_n", busy_n, 1'b0);
    check("rst dout_e", dout_e, 8'h00);
    check("rst done_e", done_e, 1'b0);
    check("rst fe_e",   fe_e,   1'b0);
    check("rst pe_e",   pe_e,   1'b0);
    check("rst busy_e", busy_e, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 20);

    // 0xA5 with latency measurement: donerx within 306+/-1 clocks of first synced low.
    c0 = cnt_n;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, BIT, -1);
    drive(1'b0, 1'b1, 40);
    check("a5 count", cnt_n - c0, 1);
    check("a5 dout", cap_dout_n, 8'hA5);
    check("a5 fe", cap_fe_n, 1'b0);
    lat = t_done_n - t_start;
    checks++;
    if (lat < 307 || lat > 309) begin
      errors++;
      $display("FAIL a5 latency: got %0d clocks from rx edge expected 307..309", lat);
    end

    // Table of complete frames.
    for (int i = 0; i < NV; i++) begin
      c0 = vecs[i].sel ? cnt_e : cnt_n;
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].sel, vecs[i].pbit, vecs[i].stopb, BIT, -1);
      drive(vecs[i].sel, 1'b1, 40);
      check($sformatf("v%0d count", i), (vecs[i].sel ? cnt_e : cnt_n) - c0, 1);
      check($sformatf("v%0d dout", i), vecs[i].sel ? cap_dout_e : cap_dout_n, vecs[i].exp_dout);
      check($sformatf("v%0d fe", i), vecs[i].sel ? cap_fe_e : cap_fe_n, vecs[i].exp_fe);
      check($sformatf("v%0d pe", i), vecs[i].sel ? cap_pe_e : cap_pe_n, vecs[i].exp_pe);
    end

    // False start: 16 clocks low then high.
    c0 = cnt_n;
    drive(1'b0, 1'b0, 16);
    check("fs busy high", busy_n, 1'b1);
    drive(1'b0, 1'b1, 40);
    check("fs busy low", busy_n, 1'b0);
    check("fs no done", cnt_n - c0, 0);

    // Break: stop bit low and line held low for 400 clocks.
    c0 = cnt_n;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 400, -1);
    check("brk count", cnt_n - c0, 1);
    check("brk dout", cap_dout_n, 8'h3C);
    check("brk fe", cap_fe_n, 1'b1);
    check("brk busy waiting", busy_n, 1'b1);
    drive(1'b0, 1'b1, 40);
    check("brk busy released", busy_n, 1'b0);
    check("brk single frame", cnt_n - c0, 1);

    // Single-clock glitch at tick 8 of data bit 3.
    c0 = cnt_n;
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, BIT, 3);
    drive(1'b0, 1'b1, 40);
    check("glitch count", cnt_n - c0, 1);
    check("glitch dout", cap_dout_n, 8'hFF);

    // Abort by dropping en_rx during data bit 4 of 0x55.
    c0 = cnt_n;
    v8 = 8'h55;
    drive(1'b0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b0, v8[i], BIT);
    en_rx = 1'b0;
    drive(1'b0, v8[4], 3);
    check("abort busy", busy_n, 1'b0);
    drive(1'b0, v8[4], BIT - 3);
    for (int i = 5; i < 8; i++) drive(1'b0, v8[i], BIT);
    drive(1'b0, 1'b1, BIT);
    en_rx = 1'b1;
    drive(1'b0, 1'b1, 40);
    check("abort no done", cnt_n - c0, 0);
    check("abort dout held", dout_n, 8'hFF);

    // Reset during data bit 4 of 0x81, then a fresh 0x81.
    v8 = 8'h81;
    drive(1'b0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'b0, v8[i], BIT);
    drive(1'b0, v8[4], 10);
    rst = 1'b1;
    drive(1'b0, v8[4], 2);
    check("mid rst dout", dout_n, 8'h00);
    check("mid rst done", done_n, 1'b0);
    check("mid rst fe", fe_n, 1'b0);
    check("mid rst pe", pe_n, 1'b0);
    check("mid rst busy", busy_n, 1'b0);
    drive(1'b0, 1'b1, 5);
    rst = 1'b0;
    drive(1'b0, 1'b1, 20);
    c0 = cnt_n;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, BIT, -1);
    drive(1'b0, 1'b1, 40);
    check("post rst count", cnt_n - c0, 1);
    check("post rst dout", cap_dout_n, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The module SHALL have parameter clk_freq, default 1000000, meaning the system clock frequency in Hz.
REQ-002 The module SHALL have parameter baud_rate, default 9600, meaning the line bit rate.
REQ-003 The module SHALL have parameter PARITY, default PAR_NONE (type uart_pkg::parity_e), meaning the parity mode: none, even or odd.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-007 The module SHALL have port en_rx, input, 1 bit: receive enable.
REQ-008 The module SHALL have port doutrx, output, 8 bits: the last received byte.
REQ-009 The module SHALL have port donerx, output, 1 bit: a one-cycle pulse marking a new doutrx.
REQ-010 The module SHALL have port frame_err, output, 1 bit: a one-cycle pulse with donerx when the stop bit was sampled low.
REQ-011 The module SHALL have port parity_err, output, 1 bit: a one-cycle pulse with donerx on parity mismatch; it stays 0 when PARITY=PAR_NONE.
REQ-012 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic SHALL use the synchronized value rxs.
REQ-014 A tick SHALL be generated every DIV=clk_freq/(baud_rate*16) clocks (integer division, minimum 1), i.e. 16 ticks per bit.
REQ-015 The tick divider and the 4-bit tick counter SHALL both restart at 0 on the cycle a start is detected.
REQ-016 The states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE: a falling edge on rxs (previous 1, now 1->0) while en_rx=1 SHALL move the FSM to START.
REQ-018 A bit value SHALL be the 2-of-3 majority of rxs taken at ticks 7, 8 and 9 of that bit; the decision SHALL be made at tick 9.
REQ-019 START: a majority of 1 SHALL be treated as a false start and return the FSM to IDLE with no pulses; a majority of 0 SHALL wait to tick 15, then go to DATA.
REQ-020 DATA: 8 bits SHALL be shifted in LSB first; a 3-bit bit counter SHALL advance at tick 15; after bit 7 the FSM SHALL go to PARITY if enabled, else to STOP.
REQ-021 PARITY: even mode SHALL expect XOR(data, parity bit)=0; odd mode SHALL expect it to be 1; the mismatch SHALL be latched internally.
REQ-022 STOP: at tick 9 the FSM SHALL load doutrx, pulse donerx for 1 cycle, pulse frame_err if the majority is 0, and pulse parity_err if latched.
REQ-023 After STOP, the FSM SHALL go to IDLE if the stop majority was 1, else to WAIT_HIGH.
REQ-024 WAIT_HIGH (break/framing recovery) SHALL stay until rxs=1, then go to IDLE; no start SHALL be detected while in WAIT_HIGH.
REQ-025 doutrx SHALL hold its value until the next donerx; it SHALL be updated even when frame_err or parity_err is set.
REQ-026 en_rx deasserted mid-frame SHALL abort the frame: the FSM SHALL go to IDLE on the next cycle, emit no pulses and leave doutrx unchanged.
REQ-027 The latency from the first rxs=0 cycle to donerx SHALL be (9 + parity bit count)*16*DIV + 9*DIV clocks, within +/-1 clock.
REQ-028 A falling edge arriving in the same cycle that STOP completes SHALL not be lost; IDLE SHALL check (prev rxs=1, rxs=0) on its first cycle.

Reset
REQ-029 Asserting rst SHALL asynchronously force: state=IDLE, doutrx=8'h00, donerx=0, frame_err=0, parity_err=0, busy=0, synchronizer flops=1, and all counters and the shift register to 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release, reception SHALL resume only on a fresh falling edge.

Structure
REQ-031 Package uart_pkg SHALL hold parity_e (PAR_NONE, PAR_EVEN, PAR_ODD), rx_state_e and the constant OVERSAMPLE=16.
REQ-032 The tick divider SHALL be a sub-module uart_baud_tick (ports: clk, rst, restart, tick) that is reusable by the transmitter.

Verification (clk_freq=3200000, baud_rate=100000: DIV=2, bit=32 clocks)
REQ-033 Frame 0x A5, PAR_NONE, valid stop -> doutrx=8'hA5, donerx for 1 cycle, frame_err=0, latency 9*32+18 clocks +/-1.
REQ-034 Line low for 16 clocks, then high -> false start: no donerx, FSM returns to IDLE, busy drops.
REQ-035 Byte 0x3C with stop bit 0 and line held low for 400 clocks -> donerx and frame_err pulse with doutrx=8'h3C; no second frame until the line returns high.
REQ-036 PAR_EVEN: byte 0x07 with parity bit 0 -> parity_err=1; the same byte with parity bit 1 -> parity_err=0.
REQ-037 A single-clock glitch to 0 at tick 8 of data bit 3 of 0xFF -> doutrx=8'hFF (majority filter).
REQ-038 rst asserted at data bit 4, then a fresh 0x81 frame -> outputs 0 during reset, then doutrx=8'h81 with exactly one donerx.
